mlp_feature_sequencer: RTL and testbench
========================================

// Module: mlp_feature_sequencer
// PURPOSE
// - Clocked front end for the combinational printed-MLP classifier. The
//   classifier takes a packed 16-bit feature vector and produces a 2-bit class.
// - Accepts features one per valid/ready beat, packs them into a stable vector
//   that drives the classifier input, and waits a programmable settle time for
//   the slow combinational logic.
// - Captures the class index and presents it downstream on a valid/ready port.
// PARAMETERS
// - N_FEAT         4   features per sample (>=2)
// - FEAT_W         4   bits per feature
// - CLS_W          2   class index width
// - SETTLE_CYCLES  4   cycles between vector completion and class capture (>=1)
// PORTS
// - clk         in   1              clock, rising edge
// - rst_n       in   1              asynchronous reset, active low
// - s_valid     in   1              feature beat valid
// - s_ready     out  1              sequencer accepts a feature
// - s_data      in   FEAT_W         feature value, unsigned
// - mlp_inp     out  N_FEAT*FEAT_W  packed vector to the classifier
// - mlp_out     in   CLS_W          class index from the classifier
// - m_valid     out  1              class result valid
// - m_ready     in   1              downstream accepts result
// - m_class     out  CLS_W          captured class index
// - busy        out  1              high in SETTLE or RESULT
// - m_mismatch  out  1              only with MLP_RESAMPLE_CHECK_EN
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous, active low (rst_n).
// - Reset: state=LOAD, beat count=0, mlp_inp=0, m_class=0, m_valid=0.
//   Also s_ready=1, busy=0, m_mismatch=0.
// - FSM states: LOAD, SETTLE, RESULT.
// - LOAD: s_ready=1. A beat transfers when s_valid&&s_ready on a rising edge.
//   - Beat k (k=0..N_FEAT-1) writes mlp_inp[k*FEAT_W +: FEAT_W].
//   - All other fields hold their value; no clearing between samples.
//   - Beat N_FEAT-1 moves the FSM to SETTLE and loads the settle counter
//     with SETTLE_CYCLES-1.
// - SETTLE: s_ready=0 and mlp_inp is frozen. The counter decrements each cycle.
//   - At counter==0, mlp_out is registered into m_class and the FSM moves
//     to RESULT.
//   - m_valid rises exactly SETTLE_CYCLES edges after the edge that accepted
//     the last beat.
// - RESULT: m_valid=1, and m_class plus mlp_inp stay stable until the handshake.
//   - On m_valid&&m_ready, the next edge clears m_valid, resets the beat count
//     to 0 and returns to LOAD.
//   - s_ready stays 0 for that cycle, so samples never overlap.
// - Back-pressure: RESULT may last any number of cycles. An s_valid beat
//   offered while not in LOAD stays pending; it is not dropped and not
//   consumed.
// - Beat count wraps from N_FEAT-1 to 0 only through the SETTLE and RESULT
//   path.
// - No arithmetic on data; widths pass through unchanged. The settle counter
//   is $clog2(SETTLE_CYCLES+1) bits wide.
// - Reset mid-operation (any state) returns to the reset values immediately
//   and discards partial vectors and pending results.
// - busy = (state != LOAD).
// CONFIGURATION
// - Macro MLP_RESAMPLE_CHECK_EN (fault-injection support).
// - Defined:
//   - mlp_out is sampled at counter==0 (into m_class) and again one cycle later.
//   - Latency becomes SETTLE_CYCLES+1.
//   - m_mismatch = (second sample != first sample), valid with m_valid and
//     cleared on handshake.
//   - m_class keeps the first sample.
// - Undefined: the m_mismatch port and its logic are absent; latency is
//   SETTLE_CYCLES.
// TESTING
// - Reset: hold rst_n=0 -> m_valid=0, s_ready=1, mlp_inp=16'h0000,
//   m_class=0, busy=0.
// - Packing: beats 3,9,F,5 with s_valid held high -> mlp_inp=16'h5F93.
//   s_ready drops the cycle after beat 4.
// - Latency: mlp_out=2'b10 steady, SETTLE_CYCLES=4 -> m_valid rises 4 edges
//   after the last beat, with m_class=2'b10.
// - Back-pressure: m_ready=0 for 10 cycles -> m_valid, m_class and mlp_inp
//   stay stable. A new s_valid beat is not taken until one cycle after
//   m_ready=1.
// - Reset mid-SETTLE: assert rst_n=0 at counter==2 -> immediate reset values.
//   The next 4 beats form a fresh vector.
// - With MLP_RESAMPLE_CHECK_EN: mlp_out changes 01->11 one cycle after first
//   capture -> m_class=01, m_mismatch=1. Steady mlp_out gives m_mismatch=0.

Source files
------------

// File: rtl/mlp_feature_sequencer.sv
// Clocked front end for the combinational printed-MLP classifier: packs feature
// beats into a frozen vector, waits a settle time, then presents the class.
// Optional macro MLP_RESAMPLE_CHECK_EN adds a second class sample and m_mismatch.
//
// state  | meaning
// LOAD   | accepting feature beats into mlp_inp
// SETTLE | vector frozen, counting down while the classifier settles
// RESULT | class captured, m_valid held until downstream handshake
module mlp_feature_sequencer #(
    parameter int N_FEAT        = 4,
    parameter int FEAT_W        = 4,
    parameter int CLS_W         = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]         mlp_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     busy
`ifdef MLP_RESAMPLE_CHECK_EN
    ,
    output logic                     m_mismatch
`endif
);

    localparam int BEAT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_FEAT*FEAT_W-1:0]  inp_q, inp_d;
    logic [CLS_W-1:0]          cls_q, cls_d;
`ifdef MLP_RESAMPLE_CHECK_EN
    logic                      resample_q, resample_d;
    logic                      mismatch_q, mismatch_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            beat_q  <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            cls_q   <= '0;
`ifdef MLP_RESAMPLE_CHECK_EN
            resample_q <= 1'b0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            cls_q   <= cls_d;
`ifdef MLP_RESAMPLE_CHECK_EN
            resample_q <= resample_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        inp_d   = inp_q;
        cls_d   = cls_q;
        s_ready = 1'b0;
`ifdef MLP_RESAMPLE_CHECK_EN
        resample_d = resample_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    inp_d[int'(beat_q)*FEAT_W +: FEAT_W] = s_data;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef MLP_RESAMPLE_CHECK_EN
                    // Counter parks at zero for one extra cycle to take the
                    // confirming sample; m_class keeps the first one.
                    if (!resample_q) begin
                        cls_d      = mlp_out;
                        resample_d = 1'b1;
                    end else begin
                        mismatch_d = (mlp_out != cls_q);
                        resample_d = 1'b0;
                        state_d    = ST_RESULT;
                    end
`else
                    cls_d   = mlp_out;
                    state_d = ST_RESULT;
`endif
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
`ifdef MLP_RESAMPLE_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_LOAD;
                beat_d  = '0;
            end
        endcase
    end

    assign mlp_inp = inp_q;
    assign m_class = cls_q;
    assign m_valid = (state_q == ST_RESULT);
    assign busy    = (state_q != ST_LOAD);
`ifdef MLP_RESAMPLE_CHECK_EN
    assign m_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Directed bench for mlp_feature_sequencer: reset, packing, latency,
// back-pressure, mid-settle reset and (with MLP_RESAMPLE_CHECK_EN) mismatch.
module tb_mlp_feature_sequencer;

    localparam int SETTLE = 4;
`ifdef MLP_RESAMPLE_CHECK_EN
    localparam int LAT = SETTLE + 1;
`else
    localparam int LAT = SETTLE;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic [15:0] mlp_inp;
    logic [1:0]  mlp_out;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_class;
    logic        busy;
`ifdef MLP_RESAMPLE_CHECK_EN
    logic        m_mismatch;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mlp_feature_sequencer #(
        .N_FEAT(4), .FEAT_W(4), .CLS_W(2), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .busy(busy)
`ifdef MLP_RESAMPLE_CHECK_EN
        , .m_mismatch(m_mismatch)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, ".mlp_inp"}, 32'(mlp_inp), 32'h0000);
        chk({tag, ".m_class"}, 32'(m_class), 32'd0);
        chk({tag, ".busy"},    32'(busy),    32'd0);
`ifdef MLP_RESAMPLE_CHECK_EN
        chk({tag, ".m_mismatch"}, 32'(m_mismatch), 32'd0);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 4'h0;
        m_ready = 1'b0;
        mlp_out = 2'b10;

        // Reset
        step(); step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // Packing 3,9,F,5 with s_valid held
        s_valid = 1'b1;
        s_data = 4'h3; step();
        chk("pack.b0", 32'(mlp_inp), 32'h0003);
        s_data = 4'h9; step();
        s_data = 4'hF; step();
        chk("pack.b2.s_ready", 32'(s_ready), 32'd1);
        s_data = 4'h5; step();
        chk("pack.vec", 32'(mlp_inp), 32'h5F93);
        chk("pack.s_ready_drop", 32'(s_ready), 32'd0);
        chk("pack.busy", 32'(busy), 32'd1);
        // Beat A stays pending through SETTLE/RESULT
        s_data = 4'hA;

        // Latency
        for (int i = 1; i < LAT; i++) begin
            step();
            chk("lat.m_valid_low", 32'(m_valid), 32'd0);
            chk("lat.frozen", 32'(mlp_inp), 32'h5F93);
        end
        step();
        chk("lat.m_valid_rise", 32'(m_valid), 32'd1);
        chk("lat.m_class", 32'(m_class), 32'd2);
`ifdef MLP_RESAMPLE_CHECK_EN
        chk("lat.m_mismatch_steady", 32'(m_mismatch), 32'd0);
`endif
        mlp_out = 2'b01;

        // Back-pressure for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp.m_valid", 32'(m_valid), 32'd1);
            chk("bp.m_class", 32'(m_class), 32'd2);
            chk("bp.mlp_inp", 32'(mlp_inp), 32'h5F93);
            chk("bp.s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("hs.m_valid_clr", 32'(m_valid), 32'd0);
        chk("hs.beat_not_taken", 32'(mlp_inp), 32'h5F93);
        chk("hs.s_ready", 32'(s_ready), 32'd1);
        chk("hs.busy", 32'(busy), 32'd0);
        chk("hs.m_class_hold", 32'(m_class), 32'd2);
        step();
        chk("next.beat0", 32'(mlp_inp), 32'h5F9A);
        s_valid = 1'b0;
        step();
        chk("next.idle_hold", 32'(mlp_inp), 32'h5F9A);

        // Partial sample then reset mid-SETTLE at counter==2
        s_valid = 1'b1;
        s_data = 4'h1; step();
        s_data = 4'h2; step();
        s_data = 4'h3; step();
        s_valid = 1'b0;
        chk("mid.vec", 32'(mlp_inp), 32'h321A);
        step();
        chk("mid.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        rst_n = 1'b1;

        // Fresh vector after reset
`ifdef MLP_RESAMPLE_CHECK_EN
        mlp_out = 2'b01;
`else
        mlp_out = 2'b11;
`endif
        s_valid = 1'b1;
        s_data = 4'h1; step();
        s_data = 4'h2; step();
        s_data = 4'h3; step();
        s_data = 4'h4; step();
        s_valid = 1'b0;
        chk("fresh.vec", 32'(mlp_inp), 32'h4321);
        for (int i = 1; i < SETTLE; i++) step();
        chk("fresh.pre", 32'(m_valid), 32'd0);
        step();
`ifdef MLP_RESAMPLE_CHECK_EN
        chk("mm.not_yet", 32'(m_valid), 32'd0);
        mlp_out = 2'b11;
        step();
        chk("mm.m_valid", 32'(m_valid), 32'd1);
        chk("mm.m_class_first", 32'(m_class), 32'd1);
        chk("mm.m_mismatch", 32'(m_mismatch), 32'd1);
`else
        chk("fresh.m_valid", 32'(m_valid), 32'd1);
        chk("fresh.m_class", 32'(m_class), 32'd3);
`endif
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("fresh.hs", 32'(m_valid), 32'd0);
`ifdef MLP_RESAMPLE_CHECK_EN
        chk("mm.clear", 32'(m_mismatch), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
